inst_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the combinational instruction ROM. It owns the program counter and issues one ROM read per cycle. Fetched {pc, inst} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake. It also handles branch redirects from execute and a debug halt/single-step. It sits between the ROM and the decode stage.

---
 rtl/cpu_defs.sv | 26 ++
 rtl/inst_fetch_ctrl_if.sv | 25 ++
 rtl/fetch_fifo.sv | 77 +++++++
 rtl/inst_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch slice: word geometry,
// the PC step, the default reset PC, the run/halt state encoding, the
// layout of a buffered fetch entry and a PC alignment helper.
package cpu_defs;

  localparam int          WORD_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  // One buffered fetch: the PC in the upper word, the instruction below it.
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-to-decode handshake bundle. The fetch controller drives the head
// entry and its valid flag; decode answers with ready.
interface inst_fetch_ctrl_if;
  import cpu_defs::*;

  logic              if_valid;
  logic              if_ready;
  logic [WORD_W-1:0] if_pc;
  logic [WORD_W-1:0] if_inst;

  modport master (
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready
  );

  modport slave (
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs. The head is read
// combinationally from storage so a write is visible one cycle later.
// Flush empties the queue and wins over push and pop in the same cycle.
// Push into a full queue is ignored unless a pop frees a slot in the same
// cycle; pop from an empty queue is ignored.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_pop_s;
  logic             do_push_s;

  // Qualify requests against the current fill level.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != CNT_W'(0))) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r < CNT_W'(DEPTH)) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller. Owns the PC, reads the combinational ROM
// once per cycle, buffers {pc, inst} pairs in a small FIFO and hands them to
// decode over valid/ready. Branch redirects flush the buffer and retarget the
// PC; a debug halt stops fetching, with single-step fetches while halted.
module inst_fetch_ctrl
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WORD_W-1:0]  rom_addr,
  input  logic [WORD_W-1:0]  rom_inst,
  input  logic               redirect_valid,
  input  logic [WORD_W-1:0]  redirect_pc,
  input  logic               halt,
  input  logic               step,
  output logic               halted,
  inst_fetch_ctrl_if.master  dec
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [WORD_W-1:0] pc_r;
  logic [WORD_W-1:0] pc_nxt_s;
  logic              fetch_en_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;
  logic [CNT_W-1:0]  count_s;
  fetch_entry_t      din_s;
  fetch_entry_t      head_s;
  logic [2*WORD_W-1:0] fifo_dout_s;

  // Run/halt next state and the fetch enable; a fetch is skipped in the
  // first cycle halt is seen, and while halted only a step fetches.
  always_comb begin
    state_nxt_s = state_r;
    fetch_en_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
          fetch_en_s  = 1'b0;
        end else begin
          state_nxt_s = ST_RUN;
          fetch_en_s  = 1'b1;
        end
      end
      ST_HALT: begin
        if (halt) begin
          state_nxt_s = ST_HALT;
          fetch_en_s  = step;
        end else begin
          state_nxt_s = ST_RUN;
          fetch_en_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        fetch_en_s  = 1'b0;
      end
    endcase
  end

  // Handshake and FIFO control; a redirect masks valid so no wrong-path
  // entry transfers, and blocks the push of the stale fetch.
  always_comb begin
    valid_s = 1'b0;
    pop_s   = 1'b0;
    push_s  = 1'b0;
    if ((count_s != CNT_W'(0)) && !redirect_valid) begin
      valid_s = 1'b1;
    end else begin
      valid_s = 1'b0;
    end
    pop_s = valid_s && dec.if_ready;
    if (fetch_en_s && !redirect_valid &&
        ((count_s < CNT_W'(DEPTH)) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // Next PC: redirect target first, else advance on a push, else hold.
  always_comb begin
    pc_nxt_s = pc_r;
    if (redirect_valid) begin
      pc_nxt_s = align_pc(redirect_pc);
    end else if (push_s) begin
      pc_nxt_s = pc_r + PC_STEP;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // PC and run/halt state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      state_r <= ST_RUN;
    end else begin
      pc_r    <= pc_nxt_s;
      state_r <= state_nxt_s;
    end
  end

  assign din_s.pc   = pc_r;
  assign din_s.inst = rom_inst;
  assign head_s     = fetch_entry_t'(fifo_dout_s);

  fetch_fifo #(
    .WIDTH (2 * WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   (din_s),
    .dout  (fifo_dout_s),
    .count (count_s)
  );

  assign rom_addr     = pc_r;
  assign halted       = (state_r == ST_HALT);
  assign dec.if_valid = valid_s;
  assign dec.if_pc    = head_s.pc;
  assign dec.if_inst  = head_s.inst;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations on delivered beats.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        step;
  logic        halted;

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .step           (step),
    .halted         (halted),
    .dec            (bus)
  );

  logic [31:0] rom [32];
  assign rom_inst = rom[rom_addr[6:2]];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Delivered beats (PCs of completed transfers).
  logic [31:0] beats [$];

  function automatic logic [31:0] getb(input int i);
    if (i < beats.size()) return beats[i];
    return 32'hDEAD_BEEF;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.if_valid && bus.if_ready) beats.push_back(bus.if_pc);
  end

  // Reference model: buffered entries as a queue, the next PC, halted flag.
  logic [63:0] mq [$];
  logic [31:0] m_pc;
  bit          m_halted;
  bit          m_valid;
  bit          m_pop;
  bit          m_fetch;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_pc     = RST_PC;
      m_halted = 1'b0;
      check("rst_rom_addr", rom_addr, RST_PC);
      check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
      check("rst_if_pc", bus.if_pc, 32'd0);
      check("rst_if_inst", bus.if_inst, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
    end else begin
      m_valid = (mq.size() != 0) && !redirect_valid;
      check("mdl_rom_addr", rom_addr, m_pc);
      check("mdl_if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
      check("mdl_halted", {31'd0, halted}, {31'd0, m_halted});
      if (m_valid) begin
        check("mdl_if_pc", bus.if_pc, mq[0][63:32]);
        check("mdl_if_inst", bus.if_inst, mq[0][31:0]);
      end
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        m_pop   = m_valid && bus.if_ready;
        m_fetch = m_halted ? (halt && step) : !halt;
        if (m_fetch && ((mq.size() < DEPTH) || m_pop)) begin
          if (m_pop) void'(mq.pop_front());
          mq.push_back({m_pc, rom[m_pc[6:2]]});
          m_pc = m_pc + 32'd4;
        end else if (m_pop) begin
          void'(mq.pop_front());
        end
      end
      m_halted = halt;
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h3c01_1010;
    rom[1] = 32'h3c02_0101;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    step           = 1'b0;
    bus.if_ready   = 1'b1;

    // Reset then run
    tick(2);
    check("reset_rom_addr", rom_addr, 32'h0);
    rst_n = 1'b1;
    beats.delete();
    tick(1);
    check("run_first_valid", {31'd0, bus.if_valid}, 32'd1);
    check("run_first_pc", bus.if_pc, 32'h0);
    check("run_first_inst", bus.if_inst, 32'h3c01_1010);
    tick(1);
    check("run_second_pc", bus.if_pc, 32'h4);
    check("run_second_inst", bus.if_inst, 32'h3c02_0101);
    tick(1);
    check("run_beat0", getb(0), 32'h0);
    check("run_beat1", getb(1), 32'h4);

    // Backpressure from a mid-operation reset
    rst_n        = 1'b0;
    bus.if_ready = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("bp_rom_addr_frozen", rom_addr, 32'h8);
    check("bp_head_pc", bus.if_pc, 32'h0);
    beats.delete();
    bus.if_ready = 1'b1;
    tick(4);
    check("bp_beat0", getb(0), 32'h0);
    check("bp_beat1", getb(1), 32'h4);
    check("bp_beat2", getb(2), 32'h8);

    // Redirect with a full FIFO
    bus.if_ready = 1'b0;
    tick(3);
    beats.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0057;
    bus.if_ready   = 1'b1;
    #1;
    check("redir_valid_masked", {31'd0, bus.if_valid}, 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    #1;
    check("redir_bubble", {31'd0, bus.if_valid}, 32'd0);
    tick(1);
    check("redir_target_valid", {31'd0, bus.if_valid}, 32'd1);
    check("redir_target_pc", bus.if_pc, 32'h54);
    check("redir_target_inst", bus.if_inst, 32'hA000_0015);
    tick(3);
    check("redir_beat0", getb(0), 32'h54);
    check("redir_beat1", getb(1), 32'h58);

    // Redirect while popping with one entry buffered
    beats.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    check("rpop_beat0", getb(0), 32'h100);
    check("rpop_beat1", getb(1), 32'h104);

    // Halt, three steps, resume
    halt = 1'b1;
    tick(1);
    check("halt_halted", {31'd0, halted}, 32'd1);
    tick(3);
    check("halt_drained", {31'd0, bus.if_valid}, 32'd0);
    check("halt_pc_held", rom_addr, 32'h110);
    beats.delete();
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
    end
    tick(1);
    check("step_count", 32'(beats.size()), 32'd3);
    check("step_beat0", getb(0), 32'h110);
    check("step_beat1", getb(1), 32'h114);
    check("step_beat2", getb(2), 32'h118);
    check("step_pc", rom_addr, 32'h11C);
    beats.delete();
    halt = 1'b0;
    tick(1);
    check("resume_halted", {31'd0, halted}, 32'd0);
    tick(4);
    check("resume_beat0", getb(0), 32'h11C);
    check("resume_beat1", getb(1), 32'h120);

    // PC wrap
    beats.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick(1);
    redirect_valid = 1'b0;
    tick(5);
    check("wrap_beat0", getb(0), 32'hFFFF_FFF8);
    check("wrap_beat1", getb(1), 32'hFFFF_FFFC);
    check("wrap_beat2", getb(2), 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
